regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the write-data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register-address width; the register count is 2^ADDR_W.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req0_valid  input  1  SHALL indicate a write request from requester 0 (ALU writeback).
REQ-006 req0_addr  input  ADDR_W  SHALL be the destination register for requester 0.
REQ-007 req0_data  input  DATA_W  SHALL be the write data for requester 0.
REQ-008 req0_ready  output  1  SHALL indicate that requester 0 is granted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready SHALL behave identically for requester 1 (load unit).
REQ-010 rsv_valid  input  1  SHALL request a reservation of destination register rsv_addr.
REQ-011 rsv_addr  input  ADDR_W  SHALL be the register to mark pending.
REQ-012 wa  output  ADDR_W  SHALL be the register-file write address.
REQ-013 wd  output  DATA_W  SHALL be the register-file write data.
REQ-014 regwrite  output  1  SHALL be the register-file write enable.
REQ-015 pending  output  2^ADDR_W  SHALL hold one bit per register; bit set means a write to that register is outstanding.

Function
REQ-016 A request SHALL transfer in cycle N when reqX_valid and reqX_ready are both high.
REQ-017 reqX_ready SHALL be combinational, and SHALL be high only when reqX_valid is high and requester X wins arbitration.
REQ-018 A single valid requester SHALL always win.
REQ-019 When both requesters are valid, the grant SHALL go to the requester not recorded in last_grant (round-robin).
REQ-020 last_grant SHALL update to the winner on every transfer.
REQ-021 At most one ready SHALL be high per cycle.
REQ-022 Output latency SHALL be one cycle: a transfer in cycle N drives wa and wd in cycle N+1.
REQ-023 regwrite SHALL be high in cycle N+1 for exactly one cycle, unless the address is 0.
REQ-024 A transfer to address 0 SHALL be accepted (ready high) but SHALL produce regwrite=0; wa and wd still update.
REQ-025 With no transfer in cycle N, regwrite SHALL be 0 in cycle N+1; wa and wd SHALL hold their previous values.
REQ-026 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.
REQ-027 rsv_valid in cycle N with a nonzero rsv_addr SHALL set pending[rsv_addr], visible in cycle N+1.
REQ-028 A reservation to address 0 SHALL be ignored; pending[0] SHALL remain 0 at all times.
REQ-029 When regwrite is high in cycle M, pending[wa] SHALL clear, visible in cycle M+1, so data is readable when the bit drops.
REQ-030 When a set and a clear hit the same register in the same cycle, the set SHALL win: the bit stays 1.
REQ-031 Reserving an already-pending register SHALL leave the bit set; no count is kept.
REQ-032 Writes to a non-pending register SHALL proceed normally; the arbiter SHALL NOT block on pending state.

Reset
REQ-033 While rst_n=0: regwrite=0, wa=0, wd=0, pending all 0, last_grant=1 (requester 0 wins the first contention).
REQ-034 reqX_ready SHALL be 0 during reset.
REQ-035 A transfer accepted in the cycle before reset asserts SHALL be discarded (no regwrite after reset).
REQ-036 The first transfer SHALL be possible in the first cycle after rst_n rises.

Verification
REQ-037 Reset release, then req0 alone with addr=5, data=0xDEADBEEF -> req0_ready=1 in cycle N; wa=5, wd=0xDEADBEEF, regwrite=1 in N+1; regwrite=0 in N+2.
REQ-038 Both requesters valid for 4 cycles (addr 1, 2) -> grants 0,1,0,1; regwrite high in 4 consecutive cycles with wa=1,2,1,2.
REQ-039 rsv_valid with addr=7, then req1 write to 7 two cycles later -> pending[7]=1 from the cycle after the reservation; drops the cycle after regwrite.
REQ-040 Same cycle: regwrite to 9 and rsv_valid to 9 while pending[9]=1 -> pending[9] remains 1.
REQ-041 req0 write to addr 0 and rsv_valid to addr 0 -> req0_ready=1, regwrite=0, pending[0]=0.
REQ-042 Assert rst_n=0 mid-stream with pending bits set -> all outputs and pending cleared immediately (asynchronous); next contention grants requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter for a register file, with a one-cycle
// registered write port and a per-register pending (scoreboard) vector.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [ADDR_W-1:0]    wa,
  output logic [DATA_W-1:0]    wd,
  output logic                 regwrite,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int N_REG = 2**ADDR_W;

  logic              r_last_grant;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic              r_regwrite;
  logic [N_REG-1:0]  r_pending;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_xfer_addr;
  logic [DATA_W-1:0] w_xfer_data;
  logic [N_REG-1:0]  w_set;
  logic [N_REG-1:0]  w_clr;

  // r_last_grant holds the most recent winner; on contention the other side wins.
  // Gating with rst_n keeps both readies low while reset is held.
  always_comb begin
    w_gnt0 = rst_n && req0_valid && (!req1_valid || r_last_grant);
    w_gnt1 = rst_n && req1_valid && (!req0_valid || !r_last_grant);
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign w_xfer      = w_gnt0 || w_gnt1;
  assign w_xfer_addr = w_gnt1 ? req1_addr : req0_addr;
  assign w_xfer_data = w_gnt1 ? req1_data : req0_data;

  // Register 0 is hardwired: it can never be reserved, so pending[0] stays 0.
  assign w_set = (rsv_valid && (rsv_addr != '0)) ? (N_REG'(1) << rsv_addr) : '0;
  assign w_clr = r_regwrite ? (N_REG'(1) << r_wa) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_wa         <= '0;
      r_wd         <= '0;
      r_regwrite   <= 1'b0;
      r_pending    <= '0;
    end else begin
      r_regwrite <= w_xfer && (w_xfer_addr != '0);
      if (w_xfer) begin
        r_last_grant <= w_gnt1;
        r_wa         <= w_xfer_addr;
        r_wd         <= w_xfer_data;
      end
      // Set is applied after clear so a same-cycle reservation survives the write.
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign wa       = r_wa;
  assign wd       = r_wd;
  assign regwrite = r_regwrite;
  assign pending  = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: arbitration order, write-port
// latency, address-0 handling, pending set/clear priority and asynchronous reset.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              regwrite;
  logic [31:0]       pending;

  int n_pass  = 0;
  int n_total = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .wa        (wa),
    .wd        (wd),
    .regwrite  (regwrite),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rsv_valid  = 1'b0; rsv_addr  = '0;

    // Reset values, ready held low even with a valid request.
    #2;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h1111_1111;
    #1;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_wa", 64'(wa), 64'd0);
    chk("rst_wd", 64'(wd), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    req0_valid = 1'b0;
    tick();
    chk("rst_hold_regwrite", 64'(regwrite), 64'd0);

    // Single request right after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    chk("single_ready0", 64'(req0_ready), 64'd1);
    chk("single_ready1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    chk("single_regwrite", 64'(regwrite), 64'd1);
    chk("single_wa", 64'(wa), 64'd5);
    chk("single_wd", 64'(wd), 64'hDEAD_BEEF);
    tick();
    chk("single_regwrite_drop", 64'(regwrite), 64'd0);
    chk("idle_wa_hold", 64'(wa), 64'd5);
    chk("idle_wd_hold", 64'(wd), 64'hDEAD_BEEF);

    // Lone req1 transfer so requester 0 is next on contention.
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h0000_0033;
    #1;
    chk("lone1_ready1", 64'(req1_ready), 64'd1);
    chk("lone1_ready0", 64'(req0_ready), 64'd0);
    tick();
    chk("lone1_wa", 64'(wa), 64'd3);

    // Four cycles of contention: grants alternate 0,1,0,1 with no bubble.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hAAAA_0001;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready0_%0d", i), 64'(req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("rr_ready1_%0d", i), 64'(req1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
      chk($sformatf("rr_regwrite_%0d", i), 64'(regwrite), 64'd1);
      chk($sformatf("rr_wa_%0d", i), 64'(wa), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("rr_wd_%0d", i), 64'(wd), (i % 2 == 0) ? 64'hAAAA_0001 : 64'hBBBB_0002);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rr_end_regwrite", 64'(regwrite), 64'd0);

    // Reserve 7, req1 writes 7 two cycles later, bit drops after the write.
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk("rsv7_set", 64'(pending[7]), 64'd1);
    tick();
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_0777;
    #1;
    chk("rsv7_ready1", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    chk("rsv7_regwrite", 64'(regwrite), 64'd1);
    chk("rsv7_still_set", 64'(pending[7]), 64'd1);
    tick();
    chk("rsv7_cleared", 64'(pending[7]), 64'd0);

    // Set wins over clear on the same register.
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0999;
    tick();
    req0_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    chk("rsv9_regwrite", 64'(regwrite), 64'd1);
    tick();
    rsv_valid = 1'b0;
    chk("rsv9_set_wins", 64'(pending[9]), 64'd1);

    // Address 0: accepted, no regwrite, never pending.
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h0000_1234;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    #1;
    chk("zero_ready0", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0; rsv_valid = 1'b0;
    chk("zero_regwrite", 64'(regwrite), 64'd0);
    chk("zero_wa", 64'(wa), 64'd0);
    chk("zero_wd", 64'(wd), 64'h0000_1234);
    chk("zero_pending0", 64'(pending[0]), 64'd0);

    // Build up pending 3,4 (9 still set), then reset mid-stream.
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd4;
    req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h0000_0666;
    tick();
    rsv_valid = 1'b0; req0_valid = 1'b0;
    chk("pre_rst_pending", 64'(pending), 64'h0000_0218);
    chk("pre_rst_regwrite", 64'(regwrite), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_regwrite", 64'(regwrite), 64'd0);
    chk("async_rst_wa", 64'(wa), 64'd0);
    chk("async_rst_wd", 64'(wd), 64'd0);
    chk("async_rst_pending", 64'(pending), 64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_00A1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_00B2;
    #1;
    chk("post_rst_ready0", 64'(req0_ready), 64'd1);
    chk("post_rst_ready1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("post_rst_wa", 64'(wa), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
